square_seq: RTL and testbench

Sequential integer squarer: accepts an unsigned WIDTH-bit operand over a valid/ready handshake and returns its full 2·WIDTH-bit square using one shift-add iteration per clock. It is the forward (inverse-direction) companion to the team's integer square-root logic. It generates squares for checking root results and for the range-reduction paths that feed the root unit. Multi-cycle and area-lean; one operation in flight at a time.

---
 rtl/square_pkg.sv | 10 +
 rtl/square_step.sv | 26 ++
 rtl/square_seq.sv | 117 +++++++++++
 tb/tb_square_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/square_pkg.sv
// Shared types and defaults for the sequential squarer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package square_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} sq_state_t;

  localparam int SQ_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/square_step.sv
// One shift-add multiply iteration, purely combinational.
// Latency: 0 cycles (combinational).
// Backpressure: none; the owning FSM decides when to register the outputs.
//
// Ports:
//   acc, mcand, mplier                 current accumulator / multiplicand / multiplier
//   next_acc, next_mcand, next_mplier  values after one iteration
module square_step
  import square_pkg::*;
#(
  parameter int WIDTH = SQ_WIDTH_DEFAULT
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] next_acc,
  output logic [2*WIDTH-1:0] next_mcand,
  output logic [WIDTH-1:0]   next_mplier
);

  // acc never overflows: the largest square (2^WIDTH-1)^2 fits in 2*WIDTH bits.
  assign next_acc    = mplier[0] ? (acc + mcand) : acc;
  assign next_mcand  = mcand << 1;
  assign next_mplier = mplier >> 1;

endmodule

// File: rtl/square_seq.sv
// Sequential integer squarer: result = x*x using one shift-add iteration per clock.
// Latency: WIDTH cycles accept-to-out_valid (bit-length of x, min 1, with SQUARE_EARLY_EXIT_EN).
// Backpressure: one op in flight; in_ready low until the result is taken, result held while out_ready low.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready/x   operand handshake (accepted only in IDLE)
//   out_valid/out_ready   result handshake (offered only in DONE)
//   result                2*WIDTH-bit square, registered
//   busy                  high while an operation is in CALC or DONE
// Build option: define SQUARE_EARLY_EXIT_EN to leave CALC once the multiplier runs out of set bits.
module square_seq
  import square_pkg::*;
#(
  parameter int WIDTH = SQ_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  sq_state_t state, state_nxt;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;

  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] step_mcand;
  logic [WIDTH-1:0]   step_mplier;
  logic               last_iter;
  logic               calc_exit;

  square_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier     (mplier),
    .next_acc   (step_acc),
    .next_mcand (step_mcand),
    .next_mplier(step_mplier)
  );

  // count holds the number of iterations already done, so the WIDTH-th
  // iteration is the one executed while count == WIDTH-1.
  assign last_iter = (count == CW'(WIDTH - 1));

`ifdef SQUARE_EARLY_EXIT_EN
  // Once the shifted multiplier is zero no further additions can happen,
  // so acc already holds the final square.
  assign calc_exit = last_iter || (step_mplier == '0);
`else
  assign calc_exit = last_iter;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (calc_exit) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers. acc doubles as the result register: it is only
  // written on accept (cleared) and during CALC, so it stays stable in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, x};
            mplier <= x;
            count  <= '0;
          end
        end
        CALC: begin
          acc    <= step_acc;
          mcand  <= step_mcand;
          mplier <= step_mplier;
          count  <= count + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // All outputs decode from registered state only.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = acc;

endmodule

// File: tb/tb_square_seq.sv
// Directed + randomized self-checking bench for square_seq (WIDTH=32).
// Latency: n/a.
// Backpressure: exercised via held out_ready and operands offered while busy.
module tb_square_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  square_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Pick the expected latency for the current build.
  function automatic int lat(input int early, input int full);
`ifdef SQUARE_EARLY_EXIT_EN
    lat = early;
`else
    lat = full;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Starts in IDLE, #1 after an edge. Accepts xv, waits for the result,
  // checks latency and value, then completes the output handshake.
  task automatic run_op(input string tag, input logic [31:0] xv,
                        input logic [63:0] exp, input int exp_lat);
    int n;
    in_valid = 1'b1;
    x        = xv;
    tick;
    in_valid = 1'b0;
    chk({tag, "_in_ready_drop"}, {63'b0, in_ready}, 64'd0);
    chk({tag, "_busy"}, {63'b0, busy}, 64'd1);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      tick;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    chk({tag, "_result"}, result, exp);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, "_out_valid_fall"}, {63'b0, out_valid}, 64'd0);
    chk({tag, "_in_ready_rise"}, {63'b0, in_ready}, 64'd1);
  endtask

  initial begin
    int n;
    logic [31:0] xv;
    logic [63:0] exp;

    rst       = 1'b1;
    in_valid  = 1'b0;
    x         = '0;
    out_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);

    run_op("x0", 32'd0, 64'd0, lat(1, 32));
    run_op("x1", 32'd1, 64'd1, lat(1, 32));
    run_op("x46341", 32'd46341, 64'h0000_0000_8000_1219, lat(16, 32));
    run_op("xmax", 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, lat(32, 32));

    // Backpressure: result held, second operand refused while in DONE.
    in_valid = 1'b1;
    x        = 32'd12;
    tick;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      tick;
      n++;
    end
    chk("bp_latency", 64'(n), 64'(lat(4, 32)));
    chk("bp_result", result, 64'd144);
    in_valid = 1'b1;
    x        = 32'd7;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_hold_result", result, 64'd144);
      chk("bp_hold_in_ready", {63'b0, in_ready}, 64'd0);
      chk("bp_hold_out_valid", {63'b0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_release_out_valid", {63'b0, out_valid}, 64'd0);
    chk("bp_release_in_ready", {63'b0, in_ready}, 64'd1);
    run_op("bp_x7", 32'd7, 64'd49, lat(3, 32));

    // Reset in the middle of an operation discards it.
    in_valid = 1'b1;
    x        = 32'd1000;
    tick;
    in_valid = 1'b0;
    repeat (10) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_result", result, 64'd0);
    chk("midrst_busy", {63'b0, busy}, 64'd0);
    run_op("after_rst_x3", 32'd3, 64'd9, lat(2, 32));

    // Randomized operands with random input gaps and output stalls.
    for (int op = 0; op < 150; op++) begin
      xv = $urandom;
      case ($urandom_range(0, 3))
        0: xv = xv & 32'h0000_00FF;
        1: xv = xv & 32'h0000_FFFF;
        default: ;
      endcase
      exp = 64'(xv) * 64'(xv);
      repeat ($urandom_range(0, 3)) tick;
      in_valid = 1'b1;
      x        = xv;
      tick;
      in_valid = 1'b0;
      x        = $urandom;
      n = 0;
      while (out_valid !== 1'b1 && n < 100) begin
        out_ready = 1'($urandom_range(0, 1));
        tick;
        n++;
      end
      chk("rnd_out_valid_seen", {63'b0, out_valid}, 64'd1);
      chk("rnd_result", result, exp);
      n = 0;
      while (out_ready !== 1'b1) begin
        tick;
        n++;
        chk("rnd_hold_result", result, exp);
        out_ready = (n >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      tick;
      out_ready = 1'b0;
      chk("rnd_single_result", {63'b0, out_valid}, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
